// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and byte-lane helper for imem_loader
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;

  // Big-endian lane select: byte 0 is the most significant byte.
  function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/imem_checksum.sv
// rtl/imem_checksum.sv - running 32-bit image sum and trailer compare for imem_loader
module imem_checksum (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        add_en,
  input  logic [31:0] add_word,
  input  logic        cmp_en,
  input  logic [31:0] trailer,
  output logic        match,
  output logic        checksum_ok
);

  logic [31:0] sum_q, sum_d;
  logic        ok_q, ok_d;

  assign match       = (sum_q == trailer);
  assign checksum_ok = ok_q;

  always_comb begin
    sum_d = sum_q;
    ok_d  = ok_q;
    if (clear) begin
      sum_d = '0;
      ok_d  = 1'b0;
    end else begin
      if (add_en) sum_d = sum_q + add_word;
      if (cmp_en) ok_d = match;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
      ok_q  <= 1'b0;
    end else begin
      sum_q <= sum_d;
      ok_q  <= ok_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing a big-endian word stream into instruction memory
// Define IMEM_LOADER_CHECKSUM_EN to treat the in_last word as a sum-check trailer.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_word,
  input  logic              in_last,
  output logic [7:0]        instruction_mem [DEPTH_BYTES],
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-2:0] word_count,
  output logic              checksum_ok
);

  localparam int                WC_W      = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(DEPTH_BYTES - BYTES_PER_WORD);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WC_W-1:0]   word_count_q, word_count_d;
  logic              in_ready_q, cpu_reset_q, busy_q, done_q, error_q;
  logic [7:0]        mem_q [DEPTH_BYTES];
  logic              xfer, wr_en;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic              ck_clear, ck_cmp, ck_match;
`endif

  // in_ready_q is high exactly in LOAD, so xfer alone implies the LOAD state.
  assign xfer = in_valid && in_ready_q;

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    word_count_d = word_count_q;
    wr_en        = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    ck_clear     = 1'b0;
    ck_cmp       = 1'b0;
`endif
    if (start) begin
      state_d      = LOAD;
      wr_addr_d    = '0;
      word_count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ck_clear     = 1'b1;
`endif
    end else if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (in_last) begin
        ck_cmp  = 1'b1;
        state_d = ck_match ? DONE : ERROR;
      end else begin
        wr_en = 1'b1;
      end
`else
      wr_en = 1'b1;
      if (in_last) state_d = DONE;
`endif
      if (wr_en) begin
        wr_addr_d    = wr_addr_q + ADDR_W'(BYTES_PER_WORD);
        word_count_d = word_count_q + WC_W'(1);
        if (!in_last && wr_addr_q == LAST_SLOT) state_d = ERROR;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_addr_q    <= '0;
      word_count_q <= '0;
      in_ready_q   <= 1'b0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      word_count_q <= word_count_d;
      in_ready_q   <= (state_d == LOAD);
      cpu_reset_q  <= (state_d != DONE);
      busy_q       <= (state_d == LOAD);
      done_q       <= (state_d == DONE);
      error_q      <= (state_d == ERROR);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_BYTES; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < BYTES_PER_WORD; k++)
        mem_q[{wr_addr_q[ADDR_W-1:2], 2'(k)}] <= be_byte(in_word, 2'(k));
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  imem_checksum u_checksum (
    .clk         (clk),
    .reset       (reset),
    .clear       (ck_clear),
    .add_en      (wr_en),
    .add_word    (in_word),
    .cmp_en      (ck_cmp),
    .trailer     (in_word),
    .match       (ck_match),
    .checksum_ok (checksum_ok)
  );
`else
  logic checksum_ok_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) checksum_ok_q <= 1'b0;
    else       checksum_ok_q <= 1'b1;
  end

  assign checksum_ok = checksum_ok_q;
`endif

  assign instruction_mem = mem_q;
  assign in_ready        = in_ready_q;
  assign cpu_reset       = cpu_reset_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign word_count      = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader (both IMEM_LOADER_CHECKSUM_EN builds)
module tb_imem_loader;

  localparam int DEPTH = 256;
  localparam int WORDS = DEPTH / 4;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [31:0] in_word = '0;
  logic        in_ready, cpu_reset, busy, done, error, checksum_ok;
  logic [6:0]  word_count;
  logic [7:0]  imem [DEPTH];

  int tests = 0;
  int fails = 0;

  logic [7:0]  ref_mem [DEPTH];
  int          ref_count;
  logic [31:0] ref_sum;
  bit          ref_busy, ref_done, ref_error, ref_ck_ok;

  typedef struct {
    logic [31:0] word;
    logic        last;
    logic [6:0]  exp_count;
    logic        exp_done;
    logic        exp_cpu_reset;
    logic        exp_ck_ok;
    logic [31:0] exp_mem_word;
  } vec_t;
  vec_t vecs [3];

  imem_loader #(.DEPTH_BYTES(DEPTH), .ADDR_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_word         (in_word),
    .in_last         (in_last),
    .instruction_mem (imem),
    .cpu_reset       (cpu_reset),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .word_count      (word_count),
    .checksum_ok     (checksum_ok)
  );

  always #5 clk = ~clk;

  // Behavioural model: image as an array of bytes, word n lands at byte 4*n.
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    ref_count = 0; ref_sum = '0;
    ref_busy = 0; ref_done = 0; ref_error = 0; ref_ck_ok = 0;
  endtask

  task automatic model_start();
    ref_busy = 1; ref_done = 0; ref_error = 0; ref_count = 0; ref_sum = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    ref_ck_ok = 0;
`endif
  endtask

  task automatic model_xfer(input logic [31:0] w, input bit last);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (last) begin
      ref_ck_ok = (ref_sum == w);
      ref_busy  = 0;
      ref_done  = ref_ck_ok;
      ref_error = !ref_ck_ok;
      return;
    end
`endif
    for (int k = 0; k < 4; k++) ref_mem[4*ref_count + k] = w[31-8*k -: 8];
    ref_sum   = ref_sum + w;
    ref_count = ref_count + 1;
    if (last) begin
      ref_busy = 0; ref_done = 1;
    end else if (ref_count == WORDS) begin
      ref_busy = 0; ref_error = 1;
    end
  endtask

  function automatic logic [31:0] mem_word(input int i);
    return {imem[4*i], imem[4*i+1], imem[4*i+2], imem[4*i+3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    int bad = -1;
    for (int i = 0; i < DEPTH; i++)
      if (bad < 0 && imem[i] !== ref_mem[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s.mem[%0d]: got %0h, expected %0h", tag, bad, imem[bad], ref_mem[bad]);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".busy"},        32'(busy),        32'(ref_busy));
    chk({tag, ".in_ready"},    32'(in_ready),    32'(ref_busy));
    chk({tag, ".done"},        32'(done),        32'(ref_done));
    chk({tag, ".error"},       32'(error),       32'(ref_error));
    chk({tag, ".cpu_reset"},   32'(cpu_reset),   32'(!ref_done));
    chk({tag, ".word_count"},  32'(word_count),  32'(ref_count));
    chk({tag, ".checksum_ok"}, 32'(checksum_ok), 32'(ref_ck_ok));
    chk_mem(tag);
  endtask

  task automatic do_start(input bit with_word, input logic [31:0] w);
    @(negedge clk);
    start = 1'b1;
    if (with_word) begin
      in_valid = 1'b1; in_word = w; in_last = 1'b0;
    end
    model_start();
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
  endtask

  // Presents one word; gives up after a few cycles without in_ready.
  task automatic send_word(input logic [31:0] w, input bit last, output bit accepted);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_word = w; in_last = last;
    while (!in_ready && n < 4) begin
      @(negedge clk);
      n++;
    end
    accepted = in_ready;
    if (accepted) model_xfer(w, last);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic rand_load(input int n);
    logic [31:0] w;
    bit acc;
    do_start(0, '0);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      w = $urandom;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (i == n - 1) w = ($urandom_range(0, 3) == 0) ? ref_sum + 32'd1 : ref_sum;
`endif
      send_word(w, i == n - 1, acc);
      chk("rand.accept", 32'(acc), 32'd1);
      @(negedge clk);
      check_all("rand");
    end
  endtask

  initial begin
    bit          acc;
    logic [31:0] w;

`ifdef IMEM_LOADER_CHECKSUM_EN
    vecs[0] = '{32'h00000001, 1'b0, 7'd1, 1'b0, 1'b1, 1'b0, 32'h00000001};
    vecs[1] = '{32'h00000002, 1'b0, 7'd2, 1'b0, 1'b1, 1'b0, 32'h00000002};
    vecs[2] = '{32'h00000003, 1'b1, 7'd2, 1'b1, 1'b0, 1'b1, 32'h00000000};
`else
    vecs[0] = '{32'h20080005, 1'b0, 7'd1, 1'b0, 1'b1, 1'b1, 32'h20080005};
    vecs[1] = '{32'h20090007, 1'b0, 7'd2, 1'b0, 1'b1, 1'b1, 32'h20090007};
    vecs[2] = '{32'h01095020, 1'b1, 7'd3, 1'b1, 1'b0, 1'b1, 32'h01095020};
`endif

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
`ifndef IMEM_LOADER_CHECKSUM_EN
    ref_ck_ok = 1;
`endif

    do_start(0, '0);
    @(negedge clk);
    check_all("start");
    for (int i = 0; i < 3; i++) begin
      send_word(vecs[i].word, vecs[i].last, acc);
      @(negedge clk);
      chk($sformatf("vec%0d.word_count", i), 32'(word_count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d.done", i), 32'(done), 32'(vecs[i].exp_done));
      chk($sformatf("vec%0d.cpu_reset", i), 32'(cpu_reset), 32'(vecs[i].exp_cpu_reset));
      chk($sformatf("vec%0d.checksum_ok", i), 32'(checksum_ok), 32'(vecs[i].exp_ck_ok));
      chk($sformatf("vec%0d.mem_word", i), mem_word(i), vecs[i].exp_mem_word);
    end
    check_all("vec.end");

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_start(0, '0);
    send_word(32'h1, 0, acc);
    send_word(32'h2, 0, acc);
    send_word(32'h4, 1, acc);
    @(negedge clk);
    chk("badsum.error", 32'(error), 32'd1);
    chk("badsum.cpu_reset", 32'(cpu_reset), 32'd1);
    chk("badsum.checksum_ok", 32'(checksum_ok), 32'd0);
    check_all("badsum");
`endif

    for (int r = 0; r < 8; r++) rand_load($urandom_range(1, 16));

    do_start(0, '0);
    send_word(32'hA5A50001, 0, acc);
    @(negedge clk);
    check_all("restart.first");
    do_start(1, 32'hDEADBEEF);
    @(negedge clk);
    chk("restart.word_count", 32'(word_count), 32'd0);
    check_all("restart.dropped");
    w = $urandom;
    send_word(w, 0, acc);
    @(negedge clk);
    chk("restart.addr0", mem_word(0), w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      send_word($urandom, 0, acc);
      @(negedge clk);
      check_all("restart.toggle");
    end

    do_start(0, '0);
    for (int i = 0; i < WORDS; i++) begin
      send_word($urandom, 0, acc);
      chk("ovf.accept", 32'(acc), 32'd1);
    end
    @(negedge clk);
    chk("ovf.error", 32'(error), 32'd1);
    chk("ovf.in_ready", 32'(in_ready), 32'd0);
    check_all("ovf");
    send_word(32'hCAFEF00D, 0, acc);
    chk("ovf.65th_rejected", 32'(acc), 32'd0);
    @(negedge clk);
    check_all("ovf.after");

    do_start(0, '0);
    for (int i = 0; i < WORDS - 1; i++) begin
      send_word($urandom, 0, acc);
      chk("bnd.accept", 32'(acc), 32'd1);
    end
    w = $urandom;
`ifdef IMEM_LOADER_CHECKSUM_EN
    w = ref_sum;
`endif
    send_word(w, 1, acc);
    @(negedge clk);
    chk("bnd.done", 32'(done), 32'd1);
    chk("bnd.error", 32'(error), 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    chk("bnd.mem252", mem_word(WORDS - 1), w);
`endif
    check_all("bnd");

    do_start(0, '0);
    send_word($urandom, 0, acc);
    send_word($urandom, 0, acc);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst.async");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
`ifndef IMEM_LOADER_CHECKSUM_EN
    ref_ck_ok = 1;
`endif
    @(negedge clk);
    check_all("rst.idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction memory writer for the pipelined MIPS core. It accepts a stream of 32-bit instruction words over a valid/ready handshake and stores them big-endian into the byte-wide instruction memory array that instruction fetch reads. While loading, it holds the core in reset, and it releases the core once the program image is complete.

## Interface
Parameters:
- DEPTH_BYTES, 256: size of the instruction memory array in bytes; must be a multiple of 4.
- ADDR_W, 8: byte address width, equal to clog2(DEPTH_BYTES).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a new load.
- in_valid  in  1  the source presents in_word.
- in_ready  out  1  the loader accepts the word this cycle.
- in_word  in  32  instruction word.
- in_last  in  1  qualifies the final word of the image.
- instruction_mem  out  [7:0] x [DEPTH_BYTES-1:0]  byte array read by instruction fetch.
- cpu_reset  out  1  drives the core's reset input.
- busy  out  1  high in LOAD.
- done  out  1  high in DONE.
- error  out  1  high in ERROR (overflow).
- word_count  out  ADDR_W-1  number of words written in the current load.
- checksum_ok  out  1  result of the image checksum (see Configuration).

## Operation
- The FSM has four states: IDLE, LOAD, DONE, ERROR.
- Reset values:
  - state IDLE, wr_addr 0, word_count 0.
  - every instruction_mem byte is 0.
  - cpu_reset 1, in_ready/busy/done/error 0, checksum_ok 0.
- IDLE: on start, go to LOAD and clear wr_addr and word_count. Memory contents are not cleared; unwritten bytes keep their old values.
- LOAD: in_ready=1.
  - A transfer is the condition in_valid && in_ready.
  - On a transfer, write mem[wr_addr]=in_word[31:24], mem[+1]=[23:16], mem[+2]=[15:8], mem[+3]=[7:0]. Then wr_addr+=4 and word_count+=1.
  - If in_last is set on the transfer, go to DONE.
  - If the transfer writes at DEPTH_BYTES-4 and in_last=0, go to ERROR. wr_addr wraps to 0 but is never used in ERROR.
  - A transfer with in_last=1 at DEPTH_BYTES-4 goes to DONE, not ERROR.
- DONE: cpu_reset=0 and done=1. A start re-enters LOAD and raises cpu_reset again.
- ERROR: in_ready=0, cpu_reset=1, error=1. Only start (to LOAD) or reset exits ERROR.
- start while in LOAD restarts the load: wr_addr=0, word_count=0, and any same-cycle transfer is dropped.
- cpu_reset is 1 in IDLE, LOAD and ERROR.

## Timing
- All outputs are registered from state; in_ready has no combinational path from in_valid.
- Throughput is one word per cycle, with in_ready held high throughout LOAD.
- Bytes are visible on instruction_mem the cycle after the accepting edge.
- Latency from the last transfer: done=1 and cpu_reset=0 appear on the next edge. Fetch starts at address 0 on the following cycle.
- The source must hold in_word/in_last stable while in_valid=1 && in_ready=0.
- Reset asserted mid-load forces all outputs to their reset values immediately, without waiting for clk, and zeroes the whole memory array.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - The word accepted with in_last is a trailer and is not written to memory; word_count does not count it.
  - The loader keeps a 32-bit running sum, modulo 2^32, of all written words. On the in_last transfer, checksum_ok is set to (sum == trailer).
  - In DONE, cpu_reset is released only if checksum_ok=1. On a mismatch, go to ERROR instead.
  - checksum_ok and the running sum are cleared on start.
- IMEM_LOADER_CHECKSUM_EN undefined: the in_last word is a normal instruction, and checksum_ok is tied to 1 outside reset.

## Structure
- Package imem_loader_pkg holds:
  - typedef enum loader_state_t {IDLE, LOAD, DONE, ERROR}.
  - localparam BYTES_PER_WORD=4.
  - The big-endian byte-lane function, which returns byte k of a word.
- Sub-module imem_checksum holds the accumulator, the compare and the clear. It is instantiated only under IMEM_LOADER_CHECKSUM_EN.

## Test plan
- Checksum off: start, then 3 words 0x20080005, 0x20090007, 0x01095020 (last on the third). Expect mem[0..3]=20 08 00 05 and mem[8..11]=01 09 50 20, word_count=3, done=1, and cpu_reset falling one cycle after the third transfer.
- Checksum on: words 0x00000001 and 0x00000002, then trailer 0x00000003 with in_last. Expect checksum_ok=1, done=1, mem[8..11] unchanged. A trailer of 0x00000004 instead gives error=1 and cpu_reset=1.
- Overflow: 64 words with in_last never set. Expect error=1 after the 64th, in_ready=0, and a 65th word not written.
- Boundary: 64 words with in_last on the 64th. Expect DONE, not ERROR, and mem[252..255] holding the 64th word.
- Reset mid-load: after 2 transfers, pulse reset between clock edges. Expect all memory bytes 0, cpu_reset=1 and state IDLE before the next clk edge.
- Backpressure and restart: in_valid toggled every other cycle, plus a start pulse during LOAD after 1 word. Expect word_count to restart at 0 and the next word to be written at byte address 0.
